// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared state encoding and header size for the instruction memory loader
package instr_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR} state_t;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// byte_packer: shifts bytes MSB-first into an S-bit word and flags the byte that completes it
module byte_packer #(
  parameter int S = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [S-1:0] word,
  output logic         last
);
  localparam int NB = S / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  logic [CW-1:0] cnt;
  logic [S-1:0]  acc;
  logic [S+7:0]  ext;
  assign ext  = {acc, din};
  assign word = ext[S-1:0];
  assign last = en && cnt == CW'(NB - 1);
  // accumulate accepted bytes; byte counter rewinds when a word completes
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (en) begin
      acc <= word;
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a byte-stream program image into instruction memory; INSTR_LOADER_CHECKSUM_EN adds a trailing checksum word
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter  int S  = 32,
  parameter  int L  = 256,
  localparam int AW = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [AW-1:0] wa,
  output logic [S-1:0]  wd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst_n
);
  localparam int HW = 8 * HDR_BYTES;
  state_t        state;
  logic [HW-1:0] n, cnt, hdr;
  logic [S-1:0]  word;
  logic          last, idle_like, go, acc;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [S-1:0]  sum;
`endif
  assign idle_like = state inside {IDLE, DONE, ERR};
  assign go        = start && idle_like;
  assign acc       = in_valid && in_ready;
  assign hdr       = {n[HW-1:8], in_data};
  assign in_ready  = state inside {HDR_HI, HDR_LO, DATA, CSUM};
  assign busy      = !idle_like;
  assign done      = state == DONE;
  assign err       = state == ERR;
  assign cpu_rst_n = !(busy || err);
  byte_packer #(.S(S)) u_packer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (go),
    .en   (acc && (state == DATA || state == CSUM)),
    .din  (in_data),
    .word (word),
    .last (last)
  );
  // load sequencer: header, data words with one write cycle each, optional checksum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
      n     <= '0;
      cnt   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (go) begin
        state <= HDR_HI;
        cnt   <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum   <= '0;
`endif
      end else begin
        case (state)
          HDR_HI: if (acc) begin
            n[HW-1:8] <= in_data;
            state     <= HDR_LO;
          end
          HDR_LO: if (acc) begin
            n[7:0] <= in_data;
            state  <= (hdr == '0 || hdr > HW'(L)) ? ERR : DATA;
          end
          DATA: if (last) begin
            we    <= 1'b1;
            wa    <= cnt[AW-1:0];
            wd    <= word;
            cnt   <= cnt + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum   <= sum + word;
`endif
            state <= WRITE;
          end
`ifdef INSTR_LOADER_CHECKSUM_EN
          WRITE: state <= (cnt == n) ? CSUM : DATA;
          CSUM: if (last) state <= (word == sum) ? DONE : ERR;
`else
          WRITE: state <= (cnt == n) ? DONE : DATA;
`endif
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized image loads checked against a queue-based write model
module tb_instr_mem_loader;
  import instr_loader_pkg::*;
  localparam int S = 32, L = 256, AW = 8;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, we, busy, done, err, cpu_rst_n;
  logic [AW-1:0] wa;
  logic [S-1:0]  wd;
  int            total = 0, bad = 0, rdy_bad = 0;
  logic [AW-1:0] wa_q[$];
  logic [S-1:0]  wd_q[$];
  logic [S-1:0]  words[$];

  instr_mem_loader #(.S(S), .L(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .err(err), .cpu_rst_n(cpu_rst_n)
  );

  always #5 clk = ~clk;

  // record every write pulse; in_ready must be low during it
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(wa);
      wd_q.push_back(wd);
      if (in_ready !== 1'b0) rdy_bad++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit thr);
    bit ok = 1'b0;
    if (thr) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=no_accept expected=accept");
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic fill(input int n);
    words.delete();
    repeat (n) words.push_back($urandom);
  endtask

  task automatic load(input int n, input bit thr, input bit mid, input bit badcs);
    logic [15:0]  hdr = 16'(n);
    logic [S-1:0] sum = '0;
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    for (int i = HDR_BYTES - 1; i >= 0; i--) send(hdr[8*i +: 8], thr);
    for (int w = 0; w < n; w++) begin
      for (int b = S / 8 - 1; b >= 0; b--) send(words[w][8*b +: 8], thr);
      sum += words[w];
      if (mid && w == 0) begin
        pulse_start();
        chk("mid_start_busy", busy, 1);
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum += S'(badcs);
    for (int b = S / 8 - 1; b >= 0; b--) send(sum[8*b +: 8], thr);
`endif
    for (int k = 0; k < 40 && busy; k++) tick();
    if (busy) begin
      total++;
      bad++;
      $error("FAIL busy_timeout observed=busy expected=idle");
    end
    chk("nwrites", wa_q.size(), n);
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk("wa", wa_q[i], i);
      chk("wd", wd_q[i], words[i]);
    end
    chk("done", done, !badcs);
    chk("err", err, badcs);
    chk("cpu_rst_n", cpu_rst_n, !badcs);
    chk("busy_end", busy, 0);
    chk("in_ready_end", in_ready, 0);
    chk("ready_in_write", rdy_bad, 0);
  endtask

  task automatic hdr_err(input logic [15:0] n);
    wa_q.delete();
    pulse_start();
    send(n[15:8], 1'b0);
    send(n[7:0], 1'b0);
    repeat (3) tick();
    chk("hdr_err", err, 1);
    chk("hdr_cpu_rst_n", cpu_rst_n, 0);
    chk("hdr_in_ready", in_ready, 0);
    chk("hdr_busy", busy, 0);
    chk("hdr_done", done, 0);
    chk("hdr_nowrite", wa_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wa"}, wa, 0);
    chk({tag, "_wd"}, wd, 0);
    chk({tag, "_cpu_rst_n"}, cpu_rst_n, 1);
  endtask

  initial begin
    repeat (2) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    words = {32'h20080005, 32'h0000000C};
    load(2, 1'b0, 1'b0, 1'b0);
    hdr_err(16'h0000);
    hdr_err(16'h0101);
    fill(3);
    load(3, 1'b0, 1'b0, 1'b0);
    load(3, 1'b1, 1'b0, 1'b0);
    fill(2);
    wa_q.delete();
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 6; i++) send(words[i / 4][8*(3 - i % 4) +: 8], 1'b0);
    chk("pre_rst_writes", wa_q.size(), 1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    tick();
    fill(2);
    load(2, 1'b0, 1'b0, 1'b0);
    fill(3);
    load(3, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      fill($urandom_range(1, 8));
      load(words.size(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    words = {32'h00000001, 32'hFFFFFFFF};
    load(2, 1'b0, 1'b0, 1'b0);
    load(2, 1'b0, 1'b0, 1'b1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
